bsg_mul_booth_radix4_iterative: RTL and testbench

//  Parametrised iterative radix-4 Booth multiplier. Computes the full 2*width_p-bit product of two

---
 rtl/bsg_mul_booth_radix4_iterative_if.sv | 25 ++
 rtl/bsg_mul_booth_radix4_iterative.sv | 128 ++++++++++++
 tb/tb_bsg_mul_booth_radix4_iterative.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/bsg_mul_booth_radix4_iterative_if.sv
// Operand/result handshake bundle for the iterative Booth multiplier.
// The master presents operands (v_i/ready_o) and consumes the product (v_o/yumi_i).
interface bsg_mul_booth_radix4_iterative_if #(
   parameter int width_p = 32
);
   logic                   v_i;
   logic                   ready_o;
   logic [width_p-1:0]     opA_i;
   logic [width_p-1:0]     opB_i;
   logic                   opA_signed_i;
   logic                   opB_signed_i;
   logic [2*width_p-1:0]   result_o;
   logic                   v_o;
   logic                   yumi_i;

   modport master (
      output v_i, opA_i, opB_i, opA_signed_i, opB_signed_i, yumi_i,
      input  ready_o, result_o, v_o
   );

   modport slave (
      input  v_i, opA_i, opB_i, opA_signed_i, opB_signed_i, yumi_i,
      output ready_o, result_o, v_o
   );
endinterface

// File: rtl/bsg_mul_booth_radix4_iterative.sv
// Iterative radix-4 Booth multiplier with per-operand signedness and optional early exit.
// Result valid 1+C cycles after capture (1 <= C <= ceil((width_p/2+1)/d)); held in eDone until yumi_i.
module bsg_mul_booth_radix4_iterative #(
   parameter int width_p            = 32,
   parameter int digits_per_cycle_p = 2,
   parameter int early_exit_p       = 1
) (
   input logic                              clk_i,
   input logic                              reset_n_i,
   bsg_mul_booth_radix4_iterative_if.slave  mul_if
);
   localparam int n_digits_lp = width_p/2 + 1;
   localparam int acc_w_lp    = 2*width_p + 4;
   localparam int b_w_lp      = width_p + 3;
   localparam int shift_lp    = 2*digits_per_cycle_p;
   localparam int cnt_w_lp    = $clog2(n_digits_lp + digits_per_cycle_p + 1);

   typedef enum logic [1:0] {eIdle, eCalc, eDone} state_e;
   state_e state_r, state_n;

   logic [acc_w_lp-1:0] acc_r, acc_n;
   logic [acc_w_lp-1:0] mx1_r, mx2_r;
   logic [b_w_lp-1:0]   b_r, b_shift;
   logic [cnt_w_lp-1:0] cnt_r, cnt_n;
   logic                fin_r;
   logic                load, step, last, all_ext;
   logic                ready, valid;

   logic                a_ext_bit, b_ext_bit;
   logic [acc_w_lp-1:0] a_sext;
   logic [b_w_lp-1:0]   b_init;

   assign a_ext_bit = mul_if.opA_signed_i & mul_if.opA_i[width_p-1];
   assign b_ext_bit = mul_if.opB_signed_i & mul_if.opB_i[width_p-1];
   assign a_sext    = {{(acc_w_lp-width_p){a_ext_bit}}, mul_if.opA_i};
   assign b_init    = {{2{b_ext_bit}}, mul_if.opB_i, 1'b0};

   // Multiplier is consumed by arithmetic shift, so retired digits refill with the extension bit
   assign b_shift = b_w_lp'($signed(b_r) >>> shift_lp);
   assign all_ext = (b_shift == {b_w_lp{b_r[b_w_lp-1]}});
   assign cnt_n   = cnt_r + cnt_w_lp'(digits_per_cycle_p);
   assign last    = (cnt_n >= cnt_w_lp'(n_digits_lp)) || ((early_exit_p != 0) && all_ext);

   logic [2:0]          trip;
   logic [acc_w_lp-1:0] mag;

   always_comb begin
      acc_n = acc_r;
      trip  = '0;
      mag   = '0;
      for (int i = 0; i < digits_per_cycle_p; i++) begin
         trip = b_r[2*i +: 3];
         mag  = '0;
         if (trip == 3'b001 || trip == 3'b010 || trip == 3'b101 || trip == 3'b110)
            mag = mx1_r << (2*i);
         else if (trip == 3'b011 || trip == 3'b100)
            mag = mx2_r << (2*i);
         if (trip[2] && !(trip[1] && trip[0]))
            acc_n = acc_n + ~mag + acc_w_lp'(1);
         else
            acc_n = acc_n + mag;
      end
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) state_r <= eIdle;
      else            state_r <= state_n;
   end

   // Termination is registered in fin_r so the wide add and the exit compare stay off the FSM path
   always_comb begin
      state_n = state_r;
      load    = 1'b0;
      step    = 1'b0;
      ready   = 1'b0;
      valid   = 1'b0;
      unique case (state_r)
         eIdle: begin
            ready = 1'b1;
            if (mul_if.v_i) begin
               load    = 1'b1;
               state_n = eCalc;
            end
         end
         eCalc: begin
            if (fin_r) state_n = eDone;
            else       step    = 1'b1;
         end
         eDone: begin
            valid = 1'b1;
            if (mul_if.yumi_i) state_n = eIdle;
         end
         default: state_n = eIdle;
      endcase
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         acc_r <= '0;
         mx1_r <= '0;
         mx2_r <= '0;
         b_r   <= '0;
         cnt_r <= '0;
         fin_r <= 1'b0;
      end else if (load) begin
         acc_r <= '0;
         mx1_r <= a_sext;
         mx2_r <= a_sext << 1;
         b_r   <= b_init;
         cnt_r <= '0;
         fin_r <= 1'b0;
      end else if (step) begin
         acc_r <= acc_n;
         mx1_r <= mx1_r << shift_lp;
         mx2_r <= mx2_r << shift_lp;
         b_r   <= b_shift;
         cnt_r <= cnt_n;
         fin_r <= last;
      end
   end

   assign mul_if.ready_o  = ready;
   assign mul_if.v_o      = valid;
   assign mul_if.result_o = acc_r[2*width_p-1:0];

   a_yumi_only_in_done: assert property (@(posedge clk_i) disable iff (!reset_n_i)
      mul_if.yumi_i |-> (state_r == eDone));
endmodule

// File: tb/tb_bsg_mul_booth_radix4_iterative.sv
// Scoreboarded bench for the Booth multiplier: directed corners, random ops, fixed-latency instance.
module tb_bsg_mul_booth_radix4_iterative;
   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   bsg_mul_booth_radix4_iterative_if #(.width_p(32)) bus ();
   bsg_mul_booth_radix4_iterative_if #(.width_p(32)) fx ();

   bsg_mul_booth_radix4_iterative #(
      .width_p(32), .digits_per_cycle_p(2), .early_exit_p(1)
   ) dut (
      .clk_i(clk), .reset_n_i(reset_n), .mul_if(bus)
   );

   bsg_mul_booth_radix4_iterative #(
      .width_p(32), .digits_per_cycle_p(2), .early_exit_p(0)
   ) dut_fx (
      .clk_i(clk), .reset_n_i(reset_n), .mul_if(fx)
   );

   typedef struct {
      logic [63:0] res;
      int          c;
   } exp_t;
   exp_t sb_q[$];

   int n_chk  = 0;
   int n_pass = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
   endtask

   function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                           input logic as, input logic bs);
      logic signed [65:0] ea, eb, p;
      ea = as ? {{34{a[31]}}, a} : {34'b0, a};
      eb = bs ? {{34{b[31]}}, b} : {34'b0, b};
      p  = ea * eb;
      return p[63:0];
   endfunction

   // Expected eCalc cycles: groups of two digits up to the last non-zero Booth digit
   function automatic int ref_cyc(input logic [31:0] b, input logic bs);
      logic [34:0] e;
      logic [2:0]  t;
      int          last_nz;
      e       = {{2{bs & b[31]}}, b, 1'b0};
      last_nz = -1;
      for (int j = 0; j < 17; j++) begin
         t = e[2*j +: 3];
         if (t != 3'b000 && t != 3'b111) last_nz = j;
      end
      return (last_nz < 0) ? 1 : (last_nz + 2) / 2;
   endfunction

   task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                         input logic as, input logic bs, input int hold);
      int   n;
      exp_t e;
      n = 0;
      check("idle_rdy", bus.ready_o, 1);
      sb_q.push_back('{res: ref_mul(a, b, as, bs), c: ref_cyc(b, bs)});
      bus.v_i = 1'b1; bus.opA_i = a; bus.opB_i = b;
      bus.opA_signed_i = as; bus.opB_signed_i = bs;
      @(posedge clk);
      @(negedge clk);
      bus.v_i = 1'b0;
      while (!bus.v_o && n < 40) begin
         @(negedge clk);
         n++;
      end
      check("v_o_seen", bus.v_o, 1);
      e = sb_q.pop_front();
      if (bus.v_o) begin
         check("latency", n, e.c + 1);
         check("result", bus.result_o, e.res);
         for (int h = 0; h < hold; h++) begin
            bus.v_i = 1'b1;
            @(negedge clk);
            check("hold_res", bus.result_o, e.res);
            check("hold_rdy", {bus.ready_o, bus.v_o}, 2'b01);
         end
         bus.yumi_i = 1'b1;
         @(negedge clk);
         bus.yumi_i = 1'b0;
         bus.v_i    = 1'b0;
         check("back_idle", {bus.ready_o, bus.v_o}, 2'b10);
      end
   endtask

   initial begin
      logic [31:0] a, b;
      logic        as, bs;
      int          n;

      bus.v_i = 0; bus.yumi_i = 0; bus.opA_i = 0; bus.opB_i = 0;
      bus.opA_signed_i = 0; bus.opB_signed_i = 0;
      fx.v_i = 0; fx.yumi_i = 0; fx.opA_i = 0; fx.opB_i = 0;
      fx.opA_signed_i = 0; fx.opB_signed_i = 0;

      #1;
      check("rst_ready", bus.ready_o, 1);
      check("rst_v", bus.v_o, 0);
      check("rst_result", bus.result_o, 64'h0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);

      run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 0);
      run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1, 1, 0);
      run_op(32'h80000000, 32'h80000000, 1, 1, 0);
      run_op(32'h00000007, 32'h00000000, 0, 0, 0);
      run_op(32'hFFFFFFFD, 32'hFFFFFFFF, 1, 0, 0);
      run_op(32'h12345678, 32'h9ABCDEF0, 0, 1, 5);
      run_op(32'h00000002, 32'h00000003, 0, 0, 0);

      // Reset during the third eCalc cycle of a long operation
      bus.v_i = 1'b1; bus.opA_i = 32'hFFFFFFFF; bus.opB_i = 32'hFFFFFFFF;
      bus.opA_signed_i = 0; bus.opB_signed_i = 0;
      @(posedge clk);
      @(negedge clk);
      bus.v_i = 1'b0;
      repeat (2) @(negedge clk);
      reset_n = 1'b0;
      #1;
      check("abort_v", bus.v_o, 0);
      check("abort_rdy", bus.ready_o, 1);
      check("abort_result", bus.result_o, 64'h0);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      run_op(32'd3, 32'd5, 0, 0, 0);

      for (int i = 0; i < 300; i++) begin
         a  = $urandom;
         b  = $urandom;
         as = 1'($urandom_range(0, 1));
         bs = 1'($urandom_range(0, 1));
         case ($urandom_range(0, 5))
            0: b = 32'($urandom_range(0, 15));
            1: b = 32'hFFFFFFFF - 32'($urandom_range(0, 15));
            2: a = 32'h80000000;
            default: ;
         endcase
         run_op(a, b, as, bs, $urandom_range(0, 2));
      end

      // Without early exit every operation takes the full digit walk
      for (int i = 0; i < 8; i++) begin
         a  = $urandom;
         b  = (i == 0) ? 32'h0 : (i == 1) ? 32'hFFFFFFFF : $urandom;
         as = 1'(i & 1);
         bs = 1'((i >> 1) & 1);
         fx.v_i = 1'b1; fx.opA_i = a; fx.opB_i = b;
         fx.opA_signed_i = as; fx.opB_signed_i = bs;
         @(posedge clk);
         @(negedge clk);
         fx.v_i = 1'b0;
         n = 0;
         while (!fx.v_o && n < 40) begin
            @(negedge clk);
            n++;
         end
         check("fx_latency", n, 10);
         check("fx_result", fx.result_o, ref_mul(a, b, as, bs));
         fx.yumi_i = 1'b1;
         @(negedge clk);
         fx.yumi_i = 1'b0;
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
